// File: rtl/ts_pkg.sv
// Shared time stamp definitions: field widths, packed layout offsets and the
// output FSM state encoding.
package ts_pkg;

    localparam int TS_ACC_W   = 4;
    localparam int TS_MS_W    = 12;
    localparam int TS_SEC_W   = 32;
    localparam int TS_W       = TS_SEC_W + TS_MS_W + TS_ACC_W;

    // Packed stamp layout: {second, millisecond, 0.1 ms}
    localparam int TS_ACC_LSB = 0;
    localparam int TS_MS_LSB  = TS_ACC_LSB + TS_ACC_W;
    localparam int TS_SEC_LSB = TS_MS_LSB + TS_MS_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ts_state_e;

    // Concatenate the generator fields verbatim; no arithmetic on the stamp.
    function automatic logic [TS_W-1:0] pack_stamp(
        input logic [TS_SEC_W-1:0] sec,
        input logic [TS_MS_W-1:0]  ms,
        input logic [TS_ACC_W-1:0] acc
    );
        return {sec, ms, acc};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after
// the last granted index, wrapping around.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N_CH-1:0] o_grant,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);

    logic w_found;
    int   w_c;

    // Circular search starting one past the pointer; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_c     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            w_c = (int'(i_ptr) + i) % N_CH;
            if (!w_found && i_req[w_c]) begin
                w_found        = 1'b1;
                o_grant[w_c]   = 1'b1;
                o_idx          = CH_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/timestamp_capture_arbiter.sv
// Captures the free-running time stamp per UART RX channel on a frame event,
// holds one stamp per channel and serialises them round-robin onto a single
// valid/ready output.
//
// Handshake: ts_valid_o rises with a stamp and holds ts_data_o/ts_ch_o stable
// until a cycle where ts_valid_o & ts_ready_i; that edge transfers the stamp.
module timestamp_capture_arbiter
    import ts_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     cap_req_i,
    input  logic [TS_ACC_W-1:0] acqurate_stamp_i,
    input  logic [TS_MS_W-1:0]  millisecond_stamp_i,
    input  logic [TS_SEC_W-1:0] second_stamp_i,
    output logic                ts_valid_o,
    input  logic                ts_ready_i,
    output logic [CH_W-1:0]     ts_ch_o,
    output logic [TS_W-1:0]     ts_data_o,
    output logic [N_CH-1:0]     overrun_o,
    input  logic [N_CH-1:0]     overrun_clr_i
);

    logic [TS_W-1:0] r_slot [N_CH];
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_overrun;
    logic [CH_W-1:0] r_ptr;
    ts_state_e       r_state;
    logic            r_valid;
    logic [CH_W-1:0] r_ch;
    logic [TS_W-1:0] r_data;

    logic [TS_W-1:0] w_stamp;
    logic [N_CH-1:0] w_grant;
    logic [CH_W-1:0] w_idx;
    logic            w_any;
    ts_state_e       w_state_nxt;
    logic            w_do_grant;
    logic            w_do_accept;
    logic [N_CH-1:0] w_grant_eff;

    assign w_stamp = pack_stamp(second_stamp_i, millisecond_stamp_i, acqurate_stamp_i);

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .i_req   (r_pending),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // FSM next state: grant from IDLE when anything is pending, return on transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        w_do_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_valid && ts_ready_i) begin
                    w_do_accept = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_grant_eff = w_do_grant ? w_grant : '0;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-channel slot, pending and sticky overrun; a grant frees the slot in
    // the same edge so a coincident request is captured rather than overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_slot[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cap_req_i[c] && (!r_pending[c] || w_grant_eff[c])) begin
                    r_slot[c]    <= w_stamp;
                    r_pending[c] <= 1'b1;
                end else if (w_grant_eff[c]) begin
                    r_pending[c] <= 1'b0;
                end
                if (cap_req_i[c] && r_pending[c] && !w_grant_eff[c]) begin
                    r_overrun[c] <= 1'b1;
                end else if (overrun_clr_i[c]) begin
                    r_overrun[c] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer; loaded on grant, dropped on transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_data  <= '0;
            r_ptr   <= CH_W'(N_CH - 1);
        end else if (w_do_grant) begin
            r_valid <= 1'b1;
            r_ch    <= w_idx;
            r_data  <= r_slot[w_idx];
            r_ptr   <= w_idx;
        end else if (w_do_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign ts_valid_o = r_valid;
    assign ts_ch_o    = r_ch;
    assign ts_data_o  = r_data;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_timestamp_capture_arbiter.sv
// Directed bench for timestamp_capture_arbiter: each feature task drives its
// own vectors and compares against hand-computed values.
module tb_timestamp_capture_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  cap_req_i;
    logic [3:0]  acqurate_stamp_i;
    logic [11:0] millisecond_stamp_i;
    logic [31:0] second_stamp_i;
    logic        ts_valid_o;
    logic        ts_ready_i;
    logic [1:0]  ts_ch_o;
    logic [47:0] ts_data_o;
    logic [3:0]  overrun_o;
    logic [3:0]  overrun_clr_i;

    int n_cmp = 0;
    int n_err = 0;

    timestamp_capture_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cap_req_i           (cap_req_i),
        .acqurate_stamp_i    (acqurate_stamp_i),
        .millisecond_stamp_i (millisecond_stamp_i),
        .second_stamp_i      (second_stamp_i),
        .ts_valid_o          (ts_valid_o),
        .ts_ready_i          (ts_ready_i),
        .ts_ch_o             (ts_ch_o),
        .ts_data_o           (ts_data_o),
        .overrun_o           (overrun_o),
        .overrun_clr_i       (overrun_clr_i)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs set after this are sampled at the next edge,
    // outputs read after this reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stamp(input logic [31:0] s, input logic [11:0] ms, input logic [3:0] acc);
        second_stamp_i      = s;
        millisecond_stamp_i = ms;
        acqurate_stamp_i    = acc;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        cap_req_i     = '0;
        overrun_clr_i = '0;
        ts_ready_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        cap_req_i     = '0;
        overrun_clr_i = '0;
        ts_ready_i    = 1'b0;
        set_stamp(32'd0, 12'd0, 4'd0);
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b0 || ts_ch_o !== 2'd0 || ts_data_o !== 48'd0 || overrun_o !== 4'd0) begin
            n_err++;
            $display("FAIL reset: valid=%b ch=%0d data=%h ovr=%b, required 0/0/0/0",
                     ts_valid_o, ts_ch_o, ts_data_o, overrun_o);
        end
        rst = 1'b0;
        tick();
    endtask

    // s=5, ms=123 (0x07B), acc=7 -> {32'h5, 12'h07B, 4'h7} = 48'h0000_0005_07B7
    task automatic test_single_capture();
        set_stamp(32'd5, 12'd123, 4'd7);
        ts_ready_i = 1'b1;
        cap_req_i  = 4'b0001;
        tick();
        cap_req_i = '0;
        n_cmp++;
        if (ts_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: valid=%b, required 0", ts_valid_o);
        end
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd0 || ts_data_o !== 48'h0000_0005_07B7) begin
            n_err++;
            $display("FAIL single_stamp: valid=%b ch=%0d data=%h, required 1/0/0000000507b7",
                     ts_valid_o, ts_ch_o, ts_data_o);
        end
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_one_cycle: valid=%b, required 0", ts_valid_o);
        end
    endtask

    // s=0x12345678, ms=999 (0x3E7), acc=9 -> 48'h1234_5678_3E79
    task automatic test_simultaneous();
        logic [1:0] exp_ch [3];
        exp_ch[0] = 2'd0;
        exp_ch[1] = 2'd1;
        exp_ch[2] = 2'd3;
        do_reset();
        set_stamp(32'h1234_5678, 12'd999, 4'd9);
        ts_ready_i = 1'b1;
        cap_req_i  = 4'b1011;
        tick();
        cap_req_i = '0;
        set_stamp(32'd0, 12'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ts_valid_o !== 1'b1 || ts_ch_o !== exp_ch[i] || ts_data_o !== 48'h1234_5678_3E79) begin
                n_err++;
                $display("FAIL simul_grant%0d: valid=%b ch=%0d data=%h, required 1/%0d/123456783e79",
                         i, ts_valid_o, ts_ch_o, ts_data_o, exp_ch[i]);
            end
            tick();
            n_cmp++;
            if (ts_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL simul_bubble%0d: valid=%b, required 0", i, ts_valid_o);
            end
        end
    endtask

    // ch2 stamp A = {32'hA, 12'd1, 4'd2} = 48'h0000_000A_0012
    // ch1 stamp B = {32'hB, 12'd500 (0x1F4), 4'd3} = 48'h0000_000B_1F43
    task automatic test_backpressure();
        do_reset();
        ts_ready_i = 1'b0;
        set_stamp(32'hA, 12'd1, 4'd2);
        cap_req_i = 4'b0100;
        tick();
        cap_req_i = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                set_stamp(32'hB, 12'd500, 4'd3);
                cap_req_i = 4'b0010;
            end else begin
                cap_req_i = '0;
                set_stamp(32'hC, 12'd7, 4'd7);
            end
            n_cmp++;
            if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd2 || ts_data_o !== 48'h0000_000A_0012) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b ch=%0d data=%h, required 1/2/0000000a0012",
                         i, ts_valid_o, ts_ch_o, ts_data_o);
            end
            tick();
        end
        cap_req_i  = '0;
        ts_ready_i = 1'b1;
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: valid=%b, required 0", ts_valid_o);
        end
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd1 || ts_data_o !== 48'h0000_000B_1F43) begin
            n_err++;
            $display("FAIL bp_next: valid=%b ch=%0d data=%h, required 1/1/0000000b1f43",
                     ts_valid_o, ts_ch_o, ts_data_o);
        end
        tick();
    endtask

    // ch1 first stamp = {32'h100, 12'd10, 4'd1} = 48'h0000_0100_00A1
    // ch2 re-request stamp E = {32'h200, 12'd20, 4'd2} = 48'h0000_0200_0142
    task automatic test_overrun();
        do_reset();
        ts_ready_i = 1'b0;
        set_stamp(32'h50, 12'd0, 4'd0);
        cap_req_i = 4'b0001;
        tick();
        cap_req_i = '0;
        tick();                               // ch0 presented, output busy
        set_stamp(32'h100, 12'd10, 4'd1);
        cap_req_i = 4'b0010;
        tick();
        set_stamp(32'h101, 12'd11, 4'd5);
        tick();                               // second ch1 request -> overrun
        cap_req_i = '0;
        n_cmp++;
        if (overrun_o !== 4'b0010) begin
            n_err++;
            $display("FAIL ovr_set: overrun=%b, required 0010", overrun_o);
        end
        ts_ready_i = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd1 || ts_data_o !== 48'h0000_0100_00A1) begin
            n_err++;
            $display("FAIL ovr_oldest: valid=%b ch=%0d data=%h, required 1/1/0000010000a1",
                     ts_valid_o, ts_ch_o, ts_data_o);
        end
        tick();
        overrun_clr_i = 4'b0010;
        tick();
        overrun_clr_i = '0;
        n_cmp++;
        if (overrun_o !== 4'b0000) begin
            n_err++;
            $display("FAIL ovr_clear: overrun=%b, required 0000", overrun_o);
        end
        // Set and clear on the same edge: set wins.
        ts_ready_i = 1'b0;
        cap_req_i  = 4'b0001;
        tick();
        cap_req_i = '0;
        tick();                               // ch0 presented again
        cap_req_i = 4'b0010;
        tick();
        cap_req_i     = 4'b0010;
        overrun_clr_i = 4'b0010;
        tick();
        cap_req_i     = '0;
        overrun_clr_i = '0;
        n_cmp++;
        if (overrun_o !== 4'b0010) begin
            n_err++;
            $display("FAIL ovr_set_wins: overrun=%b, required 0010", overrun_o);
        end
        ts_ready_i = 1'b1;
        tick();
        tick();
        tick();                               // ch0 and ch1 drained
        overrun_clr_i = 4'b0010;
        tick();
        overrun_clr_i = '0;
        // Grant and re-request on the same edge: new stamp kept, no overrun.
        set_stamp(32'h1FF, 12'd19, 4'd1);
        cap_req_i = 4'b0100;
        tick();
        set_stamp(32'h200, 12'd20, 4'd2);
        tick();                               // ch2 granted while re-requesting
        cap_req_i = '0;
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd2 || overrun_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rereq_grant: valid=%b ch=%0d overrun=%b, required 1/2/0000",
                     ts_valid_o, ts_ch_o, overrun_o);
        end
        tick();
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd2 || ts_data_o !== 48'h0000_0200_0142) begin
            n_err++;
            $display("FAIL rereq_stamp: valid=%b ch=%0d data=%h, required 1/2/000002000142",
                     ts_valid_o, ts_ch_o, ts_data_o);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_ch;
        int         grants;
        do_reset();
        exp_ch     = 2'd0;
        grants     = 0;
        ts_ready_i = 1'b1;
        cap_req_i  = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ts_valid_o === 1'b1) begin
                n_cmp++;
                if (ts_ch_o !== exp_ch) begin
                    n_err++;
                    $display("FAIL fair_order%0d: ch=%0d, required %0d", grants, ts_ch_o, exp_ch);
                end
                exp_ch = exp_ch + 2'd1;
                grants++;
            end
        end
        cap_req_i = '0;
        n_cmp++;
        if (grants != 20) begin
            n_err++;
            $display("FAIL fair_count: grants=%0d, required 20", grants);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        ts_ready_i = 1'b0;
        set_stamp(32'h77, 12'd77, 4'd7);
        cap_req_i = 4'b0111;
        tick();
        cap_req_i = '0;
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd0) begin
            n_err++;
            $display("FAIL rst_pre: valid=%b ch=%0d, required 1/0", ts_valid_o, ts_ch_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ts_valid_o !== 1'b0 || ts_ch_o !== 2'd0 || ts_data_o !== 48'd0 || overrun_o !== 4'd0) begin
            n_err++;
            $display("FAIL rst_async: valid=%b ch=%0d data=%h ovr=%b, required 0/0/0/0",
                     ts_valid_o, ts_ch_o, ts_data_o, overrun_o);
        end
        tick();
        rst        = 1'b0;
        ts_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (ts_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL rst_drop%0d: valid=%b, required 0", i, ts_valid_o);
            end
        end
        cap_req_i = 4'b1000;
        tick();
        cap_req_i = '0;
        tick();
        n_cmp++;
        if (ts_valid_o !== 1'b1 || ts_ch_o !== 2'd3 || ts_data_o !== 48'h0000_0077_04D7) begin
            n_err++;
            $display("FAIL rst_new: valid=%b ch=%0d data=%h, required 1/3/0000007704d7",
                     ts_valid_o, ts_ch_o, ts_data_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_simultaneous();
        test_backpressure();
        test_overrun();
        test_fairness();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
